// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the 8-bit memory bus: DM beats IF, requests are byte-serialised little-endian.
// Define MEMARB_IO_GAP_EN to insert one idle GAP cycle after every I/O (addr[17:16]==2'b11) access.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rdy,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_if_flush,
   output logic              o_if_done,
   output logic [DATA_W-1:0] o_if_data,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [1:0]        i_dm_len,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic              o_dm_done,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_busy,
   input  logic [7:0]        i_mem_din,
   output logic [7:0]        o_mem_dout,
   output logic [ADDR_W-1:0] o_mem_a,
   output logic              o_mem_wr
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_GAP} state_t;

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_len;
   logic [2:0]        r_k;
   logic              r_own_dm;
   logic [DATA_W-1:0] r_buf;

   logic              w_grant_dm, w_grant_if, w_abort;
   logic [2:0]        w_req_len;
   logic [ADDR_W-1:0] w_addr_k;

   assign w_grant_dm = i_dm_req;
   assign w_grant_if = !i_dm_req && i_if_req && !i_if_flush;
   assign w_req_len  = (i_dm_len == 2'b00) ? 3'd1 : (i_dm_len == 2'b01) ? 3'd2 : 3'd4;
   assign w_abort    = !r_own_dm && i_if_flush;
   assign w_addr_k   = r_addr + ADDR_W'(r_k);

   assign o_busy     = (r_state != S_IDLE);
   assign o_if_data  = r_buf;
   assign o_dm_rdata = r_buf;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   // NOTE: mem_wr and done are qualified by rdy/rst here so a frozen or aborted cycle never strobes twice.
   always_comb begin
      w_state_nx = r_state;
      o_mem_a    = '0;
      o_mem_wr   = 1'b0;
      o_mem_dout = '0;
      o_if_done  = 1'b0;
      o_dm_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_rdy) begin
               if (w_grant_dm)      w_state_nx = i_dm_we ? S_WR : S_RD;
               else if (w_grant_if) w_state_nx = S_RD;
            end
         end
         S_RD: begin
            if (r_k != r_len) o_mem_a = w_addr_k;
            if (i_rdy) begin
               if (w_abort)           w_state_nx = S_IDLE;
               else if (r_k == r_len) w_state_nx = S_DONE;
            end
         end
         S_WR: begin
            o_mem_a    = w_addr_k;
            o_mem_dout = r_buf[{r_k[1:0], 3'b000} +: 8];
            o_mem_wr   = i_rdy && !i_rst;
            if (i_rdy && (r_k == r_len - 3'd1)) w_state_nx = S_DONE;
         end
         S_DONE: begin
            o_dm_done = r_own_dm && i_rdy && !i_rst;
            o_if_done = !r_own_dm && !i_if_flush && i_rdy && !i_rst;
            if (i_rdy) begin
`ifdef MEMARB_IO_GAP_EN
               w_state_nx = (r_addr[17:16] == 2'b11) ? S_GAP : S_IDLE;
`else
               w_state_nx = S_IDLE;
`endif
            end
         end
         default: begin
            if (i_rdy) w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr   <= '0;
         r_len    <= '0;
         r_k      <= '0;
         r_own_dm <= 1'b0;
         r_buf    <= '0;
      end else if (i_rdy) begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_dm || w_grant_if) begin
                  r_own_dm <= w_grant_dm;
                  r_addr   <= w_grant_dm ? i_dm_addr : i_if_addr;
                  r_len    <= w_grant_dm ? w_req_len : 3'd4;
                  r_k      <= '0;
                  r_buf    <= (w_grant_dm && i_dm_we) ? i_dm_wdata : '0;
               end
            end
            S_RD: begin
               // mem_din carries the byte addressed in the previous RD cycle
               if (r_k != 3'd0) r_buf[{r_k[1:0] - 2'd1, 3'b000} +: 8] <= i_mem_din;
               r_k <= r_k + 3'd1;
            end
            S_WR: r_k <= r_k + 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic against a byte-array model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        if_req, if_flush, if_done;
   logic [31:0] if_addr, if_data;
   logic        dm_req, dm_we, dm_done;
   logic [1:0]  dm_len;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        busy;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
      .o_if_done(if_done), .o_if_data(if_data),
      .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_len(dm_len), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .o_dm_done(dm_done), .o_dm_rdata(dm_rdata),
      .o_busy(busy), .i_mem_din(mem_din), .o_mem_dout(mem_dout),
      .o_mem_a(mem_a), .o_mem_wr(mem_wr)
   );

   // Bus-side RAM: 4 KiB aliased on mem_a[11:0], 1-cycle registered read that freezes with rdy.
   logic [7:0]  ram [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic        ram_load;
   int unsigned seed;

   function automatic logic [7:0] init_byte(input int i, input int unsigned s);
      case (i)
         'h100:        return 8'h13;
         'h101:        return 8'h05;
         'h102, 'h103: return 8'h00;
         default:      return 8'((i * 131) ^ (i >> 4) ^ int'(s));
      endcase
   endfunction

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i, seed);
      end else begin
         if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
         if (rdy)    mem_din <= ram[mem_a[11:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
      logic [31:0] v;
      logic [11:0] idx;
      v = '0;
      for (int i = 0; i < n; i++) begin
         idx = 12'(addr + 32'(i));
         v[8*i +: 8] = ref_mem[idx];
      end
      return v;
   endfunction

   task automatic idle_cycle();
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0; rdy = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},   busy,     32'd0);
      check({tag, "_mem_wr"}, mem_wr,   32'd0);
      check({tag, "_mem_a"},  mem_a,    32'd0);
      check({tag, "_dout"},   mem_dout, 32'd0);
      check({tag, "_dones"},  {if_done, dm_done}, 32'd0);
      check({tag, "_if_data"},  if_data,  32'd0);
      check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
   endtask

   // One complete transaction started while the arbiter is idle; checks timing, bus traffic and data.
   task automatic do_txn(input bit dm, input bit we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] stall_mask, input bit rand_stall,
                         output logic [31:0] data);
      int n, base, cyc, stalls, strobes;
      bit got, gap, wr;
      logic prev_rdy;
      logic [31:0] prev_a;
      logic [11:0] idx;
      wr   = dm && we;
      n    = !dm ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      base = wr ? n + 1 : n + 2;
`ifdef MEMARB_IO_GAP_EN
      gap = (addr[17:16] == 2'b11);
`else
      gap = 1'b0;
`endif
      @(posedge clk); #1;
      rdy = 1'b1;
      if (dm) begin
         dm_req = 1'b1; dm_we = we; dm_len = len; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clk);
      check("idle_before_grant", busy, 32'd0);
      cyc = 0; stalls = 0; strobes = 0; got = 1'b0; prev_rdy = 1'b1; prev_a = '0; data = '0;
      while (!got && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         rdy = !((cyc < 32 ? stall_mask[cyc] : 1'b0) || (rand_stall && $urandom_range(5) == 0));
         if (!rdy) stalls++;
         @(negedge clk);
         if (!prev_rdy) check("stall_hold_a", mem_a, prev_a);
         if (!rdy)      check("stall_no_wr", mem_wr, 32'd0);
         if (mem_wr) begin
            check("wr_addr", mem_a, addr + 32'(strobes));
            if (strobes < 4) check("wr_byte", mem_dout, 32'(wdata[8*strobes +: 8]));
            strobes++;
         end
         if (!wr && stall_mask == 0 && !rand_stall && cyc <= n)
            check("rd_addr", mem_a, addr + 32'(cyc - 1));
         check("other_done_low", dm ? if_done : dm_done, 32'd0);
         if (dm ? dm_done : if_done) begin
            got  = 1'b1;
            data = dm ? dm_rdata : if_data;
            check("busy_in_done", busy, 32'd1);
         end
         prev_rdy = rdy;
         prev_a   = mem_a;
      end
      check("done_seen", got, 32'd1);
      check("latency", cyc, base + stalls);
      check("strobes", strobes, wr ? n : 0);
      if (wr) begin
         for (int i = 0; i < n; i++) begin
            idx = 12'(addr + 32'(i));
            ref_mem[idx] = wdata[8*i +: 8];
         end
      end else begin
         check("rd_data", data, ref_read(addr, n));
      end
      idle_cycle();
      check("post_busy", busy, gap);
      check("post_mem_a", mem_a, 32'd0);
      check("post_mem_wr", mem_wr, 32'd0);
      if (gap) begin
         idle_cycle();
         check("after_gap_busy", busy, 32'd0);
      end
   endtask

   logic [31:0] d;
   int cyc, dmc, ifc, ifa;
   logic [31:0] dmd, ifd;
   bit          r_dm, r_we;
   logic [1:0]  r_len;
   logic [31:0] r_addr, r_wd;

   initial begin
      rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_len = '0; dm_addr = '0; dm_wdata = '0;
      seed = $urandom;
      ram_load = 1'b1;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i, seed);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; ram_load = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Word fetch from 0x100 holding 13 05 00 00
      do_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 32'h0, 1'b0, d);
      check("fetch_word", d, 32'h0000_0513);

      // I/O byte write
      do_txn(1'b1, 1'b1, 2'b00, 32'h30000, 32'h41, 32'h0, 1'b0, d);

      // I/O word read at 0x30004
      do_txn(1'b1, 1'b0, 2'b11, 32'h30004, 32'h0, 32'h0, 1'b0, d);

      // Flush in IDLE: IF not granted
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h180; if_flush = 1'b1;
      @(negedge clk);
      idle_cycle();
      check("flush_idle_no_grant", busy, 32'd0);

      // Contention: DM halfword read at 0x2000 against IF fetch at 0x200
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_we = 1'b0; dm_len = 2'b01; dm_addr = 32'h2000;
      cyc = 0; dmc = -1; ifc = -1; ifa = -1; dmd = '0; ifd = '0;
      while (ifc < 0 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (dmc >= 0) dm_req = 1'b0;
         @(negedge clk);
         if (dm_done) begin dmc = cyc; dmd = dm_rdata; end
         if (if_done) begin ifc = cyc; ifd = if_data; end
         if (dmc >= 0 && ifa < 0 && mem_a == 32'h200) ifa = cyc;
      end
      check("cont_dm_done_cyc", dmc, 32'd4);
      check("cont_dm_data", dmd, ref_read(32'h2000, 2));
      check("cont_if_first_byte", ifa, 32'd6);
      check("cont_if_done_cyc", ifc, 32'd11);
      check("cont_if_data", ifd, ref_read(32'h200, 4));
      idle_cycle();

      // Flush at RD k=2 of a fetch with a DM byte read pending
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h300;
      dmc = -1; dmd = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 2) begin dm_req = 1'b1; dm_we = 1'b0; dm_len = 2'b00; dm_addr = 32'h400; end
         if (c == 3) begin if_flush = 1'b1; if_req = 1'b0; end
         if (c == 4) if_flush = 1'b0;
         if (dmc >= 0) dm_req = 1'b0;
         @(negedge clk);
         check("flush_no_if_done", if_done, 32'd0);
         if (c == 4) check("flush_idle_next", busy, 32'd0);
         if (c == 5) check("flush_dm_addr", mem_a, 32'h400);
         if (dm_done) begin dmc = c; dmd = dm_rdata; end
      end
      check("flush_dm_done_cyc", dmc, 32'd7);
      check("flush_dm_data", dmd, ref_read(32'h400, 1));
      idle_cycle();

      // rdy low for 3 cycles starting at WR k=1 of a word write, then read it back
      do_txn(1'b1, 1'b1, 2'b11, 32'h500, 32'hA1B2_C3D4, 32'h0000_001C, 1'b0, d);
      do_txn(1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 32'h0, 1'b0, d);
      check("stall_readback", d, 32'hA1B2_C3D4);

      // Reset mid-RD
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h600;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      for (int c = 0; c < 8; c++) begin
         idle_cycle();
         check("midrst_quiet", {if_done, dm_done, busy, mem_wr}, 32'd0);
      end
      do_txn(1'b0, 1'b0, 2'b11, 32'h604, 32'h0, 32'h0, 1'b0, d);

      // Random traffic with random rdy stalls
      for (int t = 0; t < 40; t++) begin
         r_dm   = 1'($urandom_range(1));
         r_we   = r_dm & 1'($urandom_range(1));
         r_len  = 2'($urandom_range(3));
         r_addr = 32'($urandom_range(32'hFFF));
         r_wd   = $urandom;
         do_txn(r_dm, r_we, r_len, r_addr, r_wd, 32'h0, 1'b1, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
